piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: word width in bits; legal range 2-32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 SHALL have parameter IDLE_LEVEL, default 0: value driven on serial_out when not shifting.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port par_in, input, WIDTH bits: parallel word to serialize.
REQ-007 SHALL have port load_valid, input, 1 bit: par_in holds a word to send.
REQ-008 SHALL have port load_ready, output, 1 bit: block accepts par_in this cycle.
REQ-009 SHALL have port serial_out, output, 1 bit: serial bit stream; feeds a serial-in/parallel-out shift register.
REQ-010 SHALL have port serial_valid, output, 1 bit: serial_out carries a data bit this cycle.
REQ-011 SHALL have port word_done, output, 1 bit: one-cycle pulse; the downstream shift register holds the complete word.
REQ-012 SHALL have port busy, output, 1 bit: a word is being shifted.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-014 SHALL register a handshake on the rising edge where load_valid=1 and load_ready=1; par_in is captured into an internal shift register at that edge.
REQ-015 SHALL drive load_ready=1 in IDLE, and in SHIFT only while the last bit (bit index WIDTH-1 of the frame) is on serial_out; otherwise 0.
REQ-016 SHALL drive load_ready combinationally from registered state, never from load_valid.
REQ-017 SHALL hold load_ready=0 in any cycle where reset=1.
REQ-018 SHALL move IDLE->SHIFT on a handshake; the first bit appears on serial_out, with serial_valid=1, in the cycle after the handshake edge (latency 1).
REQ-019 SHALL present exactly WIDTH consecutive bits, one per clock, with no gaps; the order is MSB-first when MSB_FIRST=1, else LSB-first.
REQ-020 SHALL keep a bit counter of width clog2(WIDTH); it counts 0..WIDTH-1, then wraps to 0 on a back-to-back load.
REQ-021 SHALL move SHIFT->IDLE after the last bit when no handshake occurs in the last-bit cycle; in IDLE, serial_out=IDLE_LEVEL and serial_valid=0.
REQ-022 SHALL handle a handshake in the last-bit cycle by loading the new word and staying in SHIFT; its first bit follows the previous last bit with zero idle cycles.
REQ-023 SHALL ignore load_valid while load_ready=0; par_in changes mid-frame do not affect the bits being shifted.
REQ-024 SHALL assert word_done for exactly one cycle: the cycle after each last-bit cycle, including back-to-back frames, where it coincides with the next frame's first bit.
REQ-025 SHALL drive busy=1 exactly when the state is SHIFT.
REQ-026 SHALL register serial_out, serial_valid and word_done; they are glitch-free flop outputs.

Reset
REQ-027 SHALL, on a clock edge with reset=1, set state=IDLE, counter=0, shift register=0, serial_out=IDLE_LEVEL, serial_valid=0, word_done=0 and busy=0.
REQ-028 SHALL let reset take priority over a simultaneous handshake; a word offered in a reset cycle is dropped.
REQ-029 SHALL, on reset mid-frame, abort the frame with no word_done; load_ready=1 in the first cycle after reset deasserts.

Verification
REQ-030 SHALL cover single word: WIDTH=8, MSB_FIRST=1, load 0xA5 at edge 0 -> serial_out 1,0,1,0,0,1,0,1 in cycles 1-8 with serial_valid=1; word_done=1 in cycle 9 only; busy=0 in cycle 9.
REQ-031 SHALL cover back-to-back: 0x3C, then 0xC3 accepted in the last-bit cycle -> 16 contiguous valid bits 00111100 11000011; word_done in cycles 9 and 17.
REQ-032 SHALL cover a stalled offer: load_valid=1 with par_in=0xFF during cycles 2-6 of a 0x00 frame -> load_ready=0, the frame stays all zeros, and 0xFF is accepted in cycle 8.
REQ-033 SHALL cover mid-frame reset: reset after 3 bits of 0xF0 -> next cycle serial_valid=0, serial_out=0, busy=0, load_ready=1; no word_done.
REQ-034 SHALL cover LSB-first: MSB_FIRST=0, load 0x01 -> serial_out 1,0,0,0,0,0,0,0.
REQ-035 SHALL cover loopback: serial_out drives an 8-bit serial-in/parallel-out register (bit 0 fed, shifting toward bit 7, MSB_FIRST=1); parallel_out equals the loaded word in every word_done cycle for 200 random words with random load_valid gaps.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with a valid/ready load port.
// A word offered in the last-bit cycle follows with no idle gap.
module piso_tx #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic             r_sout;
    logic             r_svalid;
    logic             r_done;

    logic             w_last;
    logic             w_take;
    logic [WIDTH-1:0] w_next;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    // r_cnt is the index of the bit currently on serial_out
    assign w_last = (r_state == S_SHIFT) && (r_cnt == LAST);
    assign load_ready = !reset && ((r_state == S_IDLE) || w_last);
    assign w_take = load_valid && load_ready;

    assign w_next = (MSB_FIRST != 0) ?
                    {r_shreg[WIDTH-2:0], 1'b0} :
                    {1'b0, r_shreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shreg  <= '0;
            r_sout   <= IDLE_LEVEL;
            r_svalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_take) begin
                r_state  <= S_SHIFT;
                r_cnt    <= '0;
                r_shreg  <= par_in;
                r_sout   <= head(par_in);
                r_svalid <= 1'b1;
            end else if (w_last) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_sout   <= IDLE_LEVEL;
                r_svalid <= 1'b0;
            end else if (r_state == S_SHIFT) begin
                r_cnt   <= r_cnt + 1'b1;
                r_shreg <= w_next;
                r_sout  <= head(w_next);
            end
        end
    end

    assign serial_out   = r_sout;
    assign serial_valid = r_svalid;
    assign word_done    = r_done;
    assign busy         = (r_state == S_SHIFT);

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx, MSB-first main instance
// with SIPO loopback, plus an LSB-first instance.
module tb_piso_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] par_in;
    logic         load_valid;
    logic         load_ready;
    logic         serial_out;
    logic         serial_valid;
    logic         word_done;
    logic         busy;

    logic [W-1:0] l_par;
    logic         l_valid;
    logic         l_ready;
    logic         l_sout;
    logic         l_svalid;
    logic         l_done;
    logic         l_busy;

    int checks = 0;
    int failures = 0;
    int n_done = 0;

    logic         bit_q[$];
    logic [W-1:0] word_q[$];
    logic [W-1:0] sipo = '0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .reset(reset), .par_in(par_in),
        .load_valid(load_valid), .load_ready(load_ready),
        .serial_out(serial_out), .serial_valid(serial_valid),
        .word_done(word_done), .busy(busy)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .par_in(l_par),
        .load_valid(l_valid), .load_ready(l_ready),
        .serial_out(l_sout), .serial_valid(l_svalid),
        .word_done(l_done), .busy(l_busy)
    );

    // downstream SIPO: bit 0 fed, shifting toward bit 7
    always @(posedge clk)
        if (serial_valid === 1'b1)
            sipo <= {sipo[W-2:0], serial_out};

    always @(negedge clk) begin
        if (serial_valid === 1'b1) begin
            checks++;
            if (bit_q.size() == 0) begin
                failures++;
                $display("FAIL bit_unexpected: got serial_out=%b, none expected", serial_out);
            end else begin
                logic eb;
                eb = bit_q.pop_front();
                if (serial_out !== eb) begin
                    failures++;
                    $display("FAIL bit_stream: got %b, expected %b at %0t", serial_out, eb, $time);
                end
            end
        end
        if (word_done === 1'b1) begin
            n_done++;
            checks++;
            if (word_q.size() == 0) begin
                failures++;
                $display("FAIL done_unexpected: word_done=1 with no word pending at %0t", $time);
            end else begin
                logic [W-1:0] ew;
                ew = word_q.pop_front();
                if (sipo !== ew) begin
                    failures++;
                    $display("FAIL loopback_word: got %h, expected %h at %0t", sipo, ew, $time);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) bit_q.push_back(w[i]);
        word_q.push_back(w);
    endtask

    task automatic test_reset();
        reset = 1'b1; load_valid = 1'b1; par_in = 8'h55;
        l_valid = 1'b0; l_par = '0;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b, expected 0", load_ready);
        end
        cyc(); cyc();
        checks++;
        if ({busy, serial_valid, serial_out, word_done, load_ready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: busy/sv/so/done/rdy=%b, expected 00000",
                     {busy, serial_valid, serial_out, word_done, load_ready});
        end
        reset = 1'b0; load_valid = 1'b0;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b, expected 1", load_ready);
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || serial_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_drop: busy=%b sv=%b, expected 0 0", busy, serial_valid);
        end
    endtask

    task automatic test_single();
        par_in = 8'hA5; load_valid = 1'b1; push_word(8'hA5);
        cyc();
        load_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            logic ev, ed, er;
            ev = (c <= 8); ed = (c == 9); er = (c >= 8);
            checks++;
            if (serial_valid !== ev || busy !== ev || word_done !== ed || load_ready !== er) begin
                failures++;
                $display("FAIL single c%0d: sv/busy/done/rdy=%b%b%b%b, expected %b%b%b%b",
                         c, serial_valid, busy, word_done, load_ready, ev, ev, ed, er);
            end
            if (c == 9) begin
                checks++;
                if (serial_out !== 1'b0) begin
                    failures++;
                    $display("FAIL single_idle_level: got %b, expected 0", serial_out);
                end
            end
            cyc();
        end
        checks++;
        if (word_done !== 1'b0) begin
            failures++;
            $display("FAIL single_done_width: got %b, expected 0", word_done);
        end
    endtask

    task automatic test_back_to_back();
        par_in = 8'h3C; load_valid = 1'b1; push_word(8'h3C);
        cyc();
        load_valid = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            logic ev, ed;
            ev = (c <= 16); ed = (c == 9 || c == 17);
            checks++;
            if (serial_valid !== ev || word_done !== ed) begin
                failures++;
                $display("FAIL b2b c%0d: sv=%b done=%b, expected %b %b",
                         c, serial_valid, word_done, ev, ed);
            end
            if (c == 8) begin
                par_in = 8'hC3; load_valid = 1'b1; push_word(8'hC3);
                checks++;
                if (load_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready: got %b, expected 1", load_ready);
                end
            end
            cyc();
            load_valid = 1'b0;
        end
    endtask

    task automatic test_stall();
        par_in = 8'h00; load_valid = 1'b1; push_word(8'h00);
        cyc();
        load_valid = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            logic ed;
            ed = (c == 9 || c == 17);
            if (c >= 2 && c <= 6) begin
                par_in = 8'hFF; load_valid = 1'b1;
                checks++;
                if (load_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_ready c%0d: got %b, expected 0", c, load_ready);
                end
            end else if (c == 8) begin
                par_in = 8'hFF; load_valid = 1'b1; push_word(8'hFF);
                checks++;
                if (load_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_accept: got %b, expected 1", load_ready);
                end
            end else begin
                load_valid = 1'b0;
            end
            checks++;
            if (word_done !== ed) begin
                failures++;
                $display("FAIL stall_done c%0d: got %b, expected %b", c, word_done, ed);
            end
            cyc();
        end
        load_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        par_in = 8'hF0; load_valid = 1'b1; push_word(8'hF0);
        cyc();
        load_valid = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ready_in_reset: got %b, expected 0", load_ready);
        end
        cyc();
        reset = 1'b0;
        bit_q.delete();
        word_q.delete();
        #1;
        checks++;
        if ({serial_valid, serial_out, busy, load_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_after: sv/so/busy/rdy=%b, expected 0001",
                     {serial_valid, serial_out, busy, load_ready});
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (word_done !== 1'b0) begin
                failures++;
                $display("FAIL midrst_no_done c%0d: got %b, expected 0", c, word_done);
            end
            cyc();
        end
    endtask

    task automatic test_lsb_first();
        logic [W-1:0] w;
        w = 8'h01;
        l_par = w; l_valid = 1'b1;
        cyc();
        l_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            checks++;
            if (l_svalid !== 1'b1 || l_sout !== w[k]) begin
                failures++;
                $display("FAIL lsb_bit%0d: sv=%b so=%b, expected 1 %b", k, l_svalid, l_sout, w[k]);
            end
            cyc();
        end
        checks++;
        if (l_done !== 1'b1 || l_svalid !== 1'b0) begin
            failures++;
            $display("FAIL lsb_done: done=%b sv=%b, expected 1 0", l_done, l_svalid);
        end
    endtask

    task automatic test_loopback();
        int sent, m_pos, guard, d0;
        logic rdy_m;
        sent = 0; m_pos = -1; guard = 0; d0 = n_done;
        while ((sent < 200 || m_pos >= 0) && guard < 5000) begin
            rdy_m = (m_pos < 0) || (m_pos == W - 1);
            par_in = W'($urandom);
            load_valid = (sent < 200) ? ($urandom_range(0, 2) != 0) : 1'b0;
            checks++;
            if (load_ready !== rdy_m || busy !== (m_pos >= 0)) begin
                failures++;
                $display("FAIL loop_ctrl: rdy=%b busy=%b, expected %b %b",
                         load_ready, busy, rdy_m, (m_pos >= 0));
            end
            if (load_valid && rdy_m) begin
                push_word(par_in);
                sent++;
                m_pos = 0;
            end else if (m_pos == W - 1) begin
                m_pos = -1;
            end else if (m_pos >= 0) begin
                m_pos++;
            end
            cyc();
            guard++;
        end
        load_valid = 1'b0;
        if (guard >= 5000) begin
            failures++;
            $display("FAIL loop_timeout: sent=%0d, expected 200 words", sent);
        end
        cyc(); cyc();
        checks++;
        if (n_done - d0 !== 200) begin
            failures++;
            $display("FAIL loop_done_count: got %0d, expected 200", n_done - d0);
        end
        checks++;
        if (bit_q.size() != 0 || word_q.size() != 0) begin
            failures++;
            $display("FAIL loop_drain: bits=%0d words=%0d left, expected 0 0",
                     bit_q.size(), word_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_lsb_first();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
